// File: rtl/alu_pkg.sv
// Shared definitions for the wide ALU command sequencer: slice width, opcode map,
// FSM encoding and opcode classification.
package alu_pkg;

    localparam int SLICE_W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_LOGIC = 2'd0,
        KIND_ARITH = 2'd1,
        KIND_RSVD  = 2'd2
    } op_kind_e;

    // Only ADD/SUB propagate carry and report overflow; 1xxx opcodes are reserved.
    function automatic op_kind_e op_kind(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOT, OP_NOR, OP_XOR, OP_NAND: return KIND_LOGIC;
            OP_ADD, OP_SUB:                                 return KIND_ARITH;
            default:                                        return KIND_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Issues a WORDS*32-bit operation to an external 32-bit combinational ALU one slice per
// cycle (LSB first), chaining carry between slices and returning the merged result and flags.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [SLICE_W*WORDS-1:0]   in_a,
    input  logic [SLICE_W*WORDS-1:0]   in_b,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   out_y,
    output logic                       out_cout,
    output logic                       out_neg,
    output logic                       out_zero,
    output logic                       out_ovf,
    output logic                       out_err,
    output logic [SLICE_W-1:0]         alu_a,
    output logic [SLICE_W-1:0]         alu_b,
    output logic [3:0]                 alu_sel,
    output logic                       alu_cin,
    input  logic [SLICE_W-1:0]         alu_y,
    input  logic                       alu_cout,
    input  logic                       alu_neg,
    input  logic                       alu_zero,
    input  logic                       alu_ovf
);

    localparam int OW    = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       op_q, op_d;
    logic [OW-1:0]    a_q, a_d;
    logic [OW-1:0]    b_q, b_d;
    logic [OW-1:0]    y_q, y_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             cout_q, cout_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             ready_q;
    logic             arith;

    assign arith     = (op_kind(op_q) == KIND_ARITH);
    assign in_ready  = ready_q && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_y     = y_q;
    assign out_cout  = cout_q;
    assign out_neg   = neg_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_err   = err_q;

    always_comb begin
        // NOTE: every _d and output gets its default first so no path through the case infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        alu_cin = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    y_d     = '0;
                    zacc_d  = 1'b1;
                    cout_d  = 1'b0;
                    neg_d   = 1'b0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = (op_kind(in_op) == KIND_RSVD);
                    state_d = (op_kind(in_op) == KIND_RSVD) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                // Operands shift down so the active slice is always the low word;
                // results shift in from the top so slice 0 lands at the bottom.
                alu_a   = a_q[SLICE_W-1:0];
                alu_b   = b_q[SLICE_W-1:0];
                alu_sel = op_q;
                alu_cin = arith & carry_q;
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                y_d     = (y_q >> SLICE_W) | (OW'(alu_y) << (OW - SLICE_W));
                carry_d = alu_cout;
                zacc_d  = zacc_q & alu_zero;
                if (idx_q == LAST_IDX) begin
                    neg_d   = alu_neg;
                    cout_d  = arith & alu_cout;
                    ovf_d   = arith & alu_ovf;
                    zero_d  = zacc_q & alu_zero;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

endmodule
